// File: rtl/updown_counter.sv
// Up/down counter with button steps, stop/up/down auto-run paced by a prescaler, and synchronous clear.
// Optional build macro: COUNTER_SATURATE_EN clamps the count at 0 and max instead of wrapping.
module updown_counter #(
  parameter int WIDTH           = 4,
  parameter int CYCLES_PER_TICK = 125_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [3:0]       buttons,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       mode,
  output logic             tick
);

  localparam int PW = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(CYCLES_PER_TICK - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    MODE_STOP = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10
  } mode_e;

  mode_e            r_mode, w_mode;
  logic [WIDTH-1:0] r_count, w_count;
  logic [PW-1:0]    r_pre, w_pre;
  logic             r_tick, w_tick;
  logic             w_autoStep;
  logic             w_manual;

  function automatic logic [WIDTH-1:0] stepCount(input logic [WIDTH-1:0] c, input logic up);
`ifdef COUNTER_SATURATE_EN
    if (up) return (c == CNT_MAX) ? c : c + WIDTH'(1);
    else    return (c == '0)      ? c : c - WIDTH'(1);
`else
    return up ? c + WIDTH'(1) : c - WIDTH'(1);
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode  <= MODE_STOP;
      r_count <= '0;
      r_pre   <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_mode  <= w_mode;
      r_count <= w_count;
      r_pre   <= w_pre;
      r_tick  <= w_tick;
    end
  end

  always_comb begin
    w_mode     = r_mode;
    w_count    = r_count;
    w_pre      = r_pre;
    w_tick     = 1'b0;
    w_autoStep = 1'b0;
    w_manual   = buttons[0] ^ buttons[1];
    if (ce) begin
      if (buttons[3]) begin
        w_count = '0;
        w_pre   = '0;
      end else if (buttons[2]) begin
        case (r_mode)
          MODE_STOP: w_mode = MODE_UP;
          MODE_UP:   w_mode = MODE_DOWN;
          default:   w_mode = MODE_STOP;
        endcase
        w_pre = '0;
      end else begin
        if (r_mode == MODE_UP || r_mode == MODE_DOWN) begin
          if (r_pre == PRE_LAST) begin
            w_pre      = '0;
            w_autoStep = 1'b1;
          end else begin
            w_pre = r_pre + PW'(1);
          end
        end else begin
          w_pre = '0;
        end
        // A manual step pre-empts a coincident auto step; the prescaler still wraps.
        if (w_manual) begin
          w_count = stepCount(r_count, buttons[0]);
        end else if (w_autoStep) begin
          w_count = stepCount(r_count, r_mode == MODE_UP);
          w_tick  = 1'b1;
        end
      end
    end
  end

  assign count = r_count;
  assign mode  = r_mode;
  assign tick  = r_tick;

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter: directed plan steps plus random stimulus against a cycle-level model.
// Model follows COUNTER_SATURATE_EN the same way the design build does.
module tb_updown_counter;

  localparam int WIDTH = 4;
  localparam int CPT   = 30;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ce = 1'b0;
  logic [3:0]       buttons = 4'b0;
  logic [WIDTH-1:0] count;
  logic [1:0]       mode;
  logic             tick;

  int nCompared = 0;
  int nMismatched = 0;

  // Reference state: elapsed cycles in the current period rather than a prescaler value
  int mCount = 0;
  int mMode = 0;
  int mElapsed = 0;
  int mTick = 0;

  updown_counter #(.WIDTH(WIDTH), .CYCLES_PER_TICK(CPT)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .buttons(buttons),
    .count(count), .mode(mode), .tick(tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int applyStep(input int c, input bit up);
`ifdef COUNTER_SATURATE_EN
    if (up) return (c == MAXV) ? c : c + 1;
    else    return (c == 0) ? c : c - 1;
`else
    return up ? (c + 1) % (MAXV + 1) : (c + MAXV) % (MAXV + 1);
`endif
  endfunction

  task automatic modelEdge(input logic iCe, input logic [3:0] b, input logic iRstN);
    bit autoStep;
    if (!iRstN) begin
      mCount = 0; mMode = 0; mElapsed = 0; mTick = 0;
    end else if (!iCe) begin
      mTick = 0;
    end else if (b[3]) begin
      mCount = 0; mElapsed = 0; mTick = 0;
    end else if (b[2]) begin
      mMode = (mMode + 1) % 3; mElapsed = 0; mTick = 0;
    end else begin
      autoStep = 1'b0;
      if (mMode != 0) begin
        mElapsed++;
        if (mElapsed == CPT) begin
          mElapsed = 0;
          autoStep = 1'b1;
        end
      end else begin
        mElapsed = 0;
      end
      mTick = 0;
      if (b[0] != b[1]) mCount = applyStep(mCount, b[0]);
      else if (autoStep) begin
        mCount = applyStep(mCount, mMode == 1);
        mTick = 1;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic iCe, input logic [3:0] b, input logic iRstN = 1'b1);
    ce = iCe;
    buttons = b;
    rst_n = iRstN;
    @(posedge clk);
    modelEdge(iCe, b, iRstN);
    #1;
    checkOutput("model count", {28'b0, count}, mCount);
    checkOutput("model mode", {30'b0, mode}, mMode);
    checkOutput("model tick", {31'b0, tick}, mTick);
    ce = 1'b1;
    buttons = 4'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int tickTimes[$];
    int elapsed;
    int r;
    bit seen;
    logic [3:0] b;

    $display("[TB] start");
    #1;
    applyStimulus(1'b1, 4'b0101, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("reset count", {28'b0, count}, 0);
    checkOutput("reset mode", {30'b0, mode}, 0);
    checkOutput("reset tick", {31'b0, tick}, 0);

    // Manual steps
    applyStimulus(1'b1, 4'b0001);
    checkOutput("inc", {28'b0, count}, 1);
    applyStimulus(1'b1, 4'b0010);
    checkOutput("dec", {28'b0, count}, 0);
    applyStimulus(1'b1, 4'b0010);
`ifdef COUNTER_SATURATE_EN
    checkOutput("dec below zero", {28'b0, count}, 0);
`else
    checkOutput("dec below zero", {28'b0, count}, 15);
`endif
    r = int'(count);
    applyStimulus(1'b1, 4'b0011);
    checkOutput("inc+dec hold", {28'b0, count}, r);
    applyStimulus(1'b0, 4'b0001);
    checkOutput("ce low ignores inc", {28'b0, count}, r);
    applyStimulus(1'b1, 4'b1000);
    checkOutput("clear", {28'b0, count}, 0);

    // Auto up: five steps spaced one period apart
    applyStimulus(1'b1, 4'b0100);
    checkOutput("mode up", {30'b0, mode}, 1);
    for (int i = 1; i <= 5 * CPT + 2; i++) begin
      applyStimulus(1'b1, 4'b0000);
      if (tick) tickTimes.push_back(i);
    end
    checkOutput("auto up count", {28'b0, count}, 5);
    checkOutput("auto up ticks", tickTimes.size(), 5);
    if (tickTimes.size() == 5)
      for (int i = 0; i < 5; i++)
        checkOutput("tick spacing", tickTimes[i], CPT * (i + 1));

    // Auto down, then stop
    applyStimulus(1'b1, 4'b0100);
    checkOutput("mode down", {30'b0, mode}, 2);
    for (int i = 0; i < 3 * CPT; i++) applyStimulus(1'b1, 4'b0000);
    checkOutput("auto down count", {28'b0, count}, 2);
    applyStimulus(1'b1, 4'b0100);
    checkOutput("mode stop", {30'b0, mode}, 0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 4'b0000);
      if (tick) seen = 1'b1;
    end
    checkOutput("stop no tick", {31'b0, seen}, 0);
    checkOutput("stop holds", {28'b0, count}, 2);

    // Disabled cycles stretch the period
    applyStimulus(1'b1, 4'b0100);
    elapsed = 0;
    for (int i = 0; i < 15; i++) begin applyStimulus(1'b1, 4'b0000); elapsed++; end
    for (int i = 0; i < 10; i++) begin applyStimulus(1'b0, 4'b0000); elapsed++; end
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      applyStimulus(1'b1, 4'b0000);
      elapsed++;
      if (tick) seen = 1'b1;
    end
    checkOutput("stretched tick seen", {31'b0, seen}, 1);
    checkOutput("stretched period", elapsed, CPT + 10);
    applyStimulus(1'b1, 4'b1001);
    checkOutput("clear beats inc", {28'b0, count}, 0);
    checkOutput("clear keeps mode", {30'b0, mode}, 1);

    // Boundary at max count under auto up
    applyStimulus(1'b1, 4'b0100);
    applyStimulus(1'b1, 4'b0100);
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 4'b0001);
    checkOutput("preset 14", {28'b0, count}, 14);
    applyStimulus(1'b1, 4'b0100);
    for (int i = 0; i < CPT; i++) applyStimulus(1'b1, 4'b0000);
    checkOutput("step to max", {28'b0, count}, 15);
    checkOutput("step to max tick", {31'b0, tick}, 1);
    for (int i = 0; i < CPT; i++) applyStimulus(1'b1, 4'b0000);
`ifdef COUNTER_SATURATE_EN
    checkOutput("step past max", {28'b0, count}, 15);
`else
    checkOutput("step past max", {28'b0, count}, 0);
`endif
    checkOutput("step past max tick", {31'b0, tick}, 1);

    // Random traffic against the model (inc and dec never together here)
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4)       b = 4'b0001;
      else if (r < 8)  b = 4'b0010;
      else if (r < 10) b = 4'b0100;
      else if (r < 11) b = 4'b1000;
      else if (r < 12) b = 4'b1001;
      else             b = 4'b0000;
      applyStimulus($urandom_range(0, 9) != 0, b, $urandom_range(0, 299) != 0);
    end

    // Reset mid-run overrides a held mode button
    for (int i = 0; i < 3 && mMode == 0; i++) applyStimulus(1'b1, 4'b0100);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'b0001);
    applyStimulus(1'b1, 4'b0100, 1'b0);
    checkOutput("reset run count", {28'b0, count}, 0);
    checkOutput("reset run mode", {30'b0, mode}, 0);
    checkOutput("reset run tick", {31'b0, tick}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
